// File: rtl/calc_bcd_display.sv
// calc_bcd_display: iterative double-dabble binary-to-BCD converter with valid/ready in, done pulse out.
// Optional seven-segment output enabled by defining CALC_BCD_SEVEN_SEG_EN.
module calc_bcd_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      din,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef CALC_BCD_SEVEN_SEG_EN
    ,
    output logic [7*DIGITS-1:0]   seg
`endif
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    if (pow10(DIGITS) <= (64'd1 << WIDTH) - 64'd1) begin : g_bad_digits
        $error("calc_bcd_display: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] shreg;
    logic [SW-1:0]   scratch, adj, next_scratch;
    logic [CW-1:0]   count;
    logic            last;

    // add-3 per digit on pre-shift values, no carry between digits
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        assign adj[4*i +: 4] = scratch[4*i +: 4] >= 4'd5 ? scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
    end

    assign next_scratch = {adj[SW-2:0], shreg[WIDTH-1]};
    assign last         = state == SHIFT && count == CW'(WIDTH - 1);
    assign in_ready     = state == IDLE;
    assign busy         = state == SHIFT;
    assign done         = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            count   <= '0;
            bcd     <= '0;
        end else if (enb) begin
            case (state)
                IDLE: if (in_valid) begin
                    shreg   <= din;
                    scratch <= '0;
                    count   <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    scratch <= next_scratch;
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    count   <= count + CW'(1);
                    if (last) begin
                        bcd   <= next_scratch;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CALC_BCD_SEVEN_SEG_EN
    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3f;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5b;
            4'd3:    return 7'h4f;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6d;
            4'd6:    return 7'h7d;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7f;
            4'd9:    return 7'h6f;
            default: return 7'h00;
        endcase
    endfunction

    logic [7*DIGITS-1:0] seg_next;
    logic                lead;
    logic [3:0]          d;

    // blank leading zeros; the least significant digit always shows
    always_comb begin
        seg_next = '0;
        lead     = 1'b1;
        d        = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            d = next_scratch[4*k +: 4];
            lead = lead && d == 4'd0 && k != 0;
            seg_next[7*k +: 7] = lead ? 7'd0 : enc(d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) seg <= '0;
        else if (enb && last) seg <= seg_next;
    end
`endif
endmodule

// File: tb/tb_calc_bcd_display.sv
// tb_calc_bcd_display: randomized self-checking bench for calc_bcd_display against a decimal-arithmetic model.
module tb_calc_bcd_display;
    logic        clk = 0, rst = 0, enb = 1, in_valid = 0;
    logic [7:0]  din = 0;
    logic        in_ready, busy, done;
    logic [11:0] bcd;
    int          pass_cnt = 0, total_cnt = 0;
`ifdef CALC_BCD_SEVEN_SEG_EN
    logic [20:0] seg;
`endif

    calc_bcd_display dut (
        .clk(clk), .rst(rst), .enb(enb), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .busy(busy), .done(done), .bcd(bcd)
`ifdef CALC_BCD_SEVEN_SEG_EN
        , .seg(seg)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [11:0] bcd_model(input int v);
        logic [11:0] r;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

`ifdef CALC_BCD_SEVEN_SEG_EN
    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b0111111; 1: return 7'b0000110; 2: return 7'b1011011;
            3: return 7'b1001111; 4: return 7'b1100110; 5: return 7'b1101101;
            6: return 7'b1111101; 7: return 7'b0000111; 8: return 7'b1111111;
            default: return 7'b1101111;
        endcase
    endfunction

    function automatic logic [20:0] seg_model(input int v);
        logic [20:0] r;
        int shown, t;
        shown = v >= 100 ? 3 : v >= 10 ? 2 : 1;
        r = '0;
        t = v;
        for (int k = 0; k < shown; k++) begin
            r[7*k +: 7] = glyph(t % 10);
            t = t / 10;
        end
        return r;
    endfunction
`endif

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Accepts v (caller guarantees IDLE and enb=1), scrambles din, waits for done.
    task automatic do_conv(input logic [7:0] v, output int lat, output bit stable);
        logic [11:0] prev;
        prev = bcd;
        stable = 1;
        lat = -1;
        din = v;
        in_valid = 1;
        cyc();
        in_valid = 0;
        for (int n = 1; n <= 40; n++) begin
            din = 8'($urandom);
            cyc();
            if (done) begin
                lat = n;
                break;
            end
            if (bcd !== prev) stable = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1;
        cyc();
        rst = 0;
        total_cnt++;
        if ({in_ready, busy, done, bcd} !== {1'b1, 1'b0, 1'b0, 12'h000})
            $display("FAIL reset: rdy/busy/done/bcd got %b%b%b %h want 100 000", in_ready, busy, done, bcd);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int lat;
        bit stable;
        int vals[4] = '{2, 153, 255, 0};
        foreach (vals[j]) begin
            do_conv(8'(vals[j]), lat, stable);
            total_cnt++;
            if (lat !== 8) $display("FAIL basic_latency din=%0d: got %0d want 8", vals[j], lat);
            else pass_cnt++;
            total_cnt++;
            if (bcd !== bcd_model(vals[j])) $display("FAIL basic_bcd din=%0d: got %h want %h", vals[j], bcd, bcd_model(vals[j]));
            else pass_cnt++;
            total_cnt++;
            if (!stable) $display("FAIL basic_no_partial din=%0d: bcd changed before done", vals[j]);
            else pass_cnt++;
`ifdef CALC_BCD_SEVEN_SEG_EN
            total_cnt++;
            if (seg !== seg_model(vals[j])) $display("FAIL basic_seg din=%0d: got %h want %h", vals[j], seg, seg_model(vals[j]));
            else pass_cnt++;
`endif
            total_cnt++;
            if ({in_ready, busy} !== 2'b00) $display("FAIL basic_done_state din=%0d: rdy/busy got %b%b want 00", vals[j], in_ready, busy);
            else pass_cnt++;
            cyc();
            total_cnt++;
            if ({in_ready, done} !== 2'b10) $display("FAIL basic_ready_back din=%0d: rdy/done got %b%b want 10", vals[j], in_ready, done);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int lat;
        bit stable;
        logic [7:0] v;
        for (int j = 0; j < 12; j++) begin
            v = 8'($urandom);
            do_conv(v, lat, stable);
            total_cnt++;
            if (lat !== 8 || bcd !== bcd_model(v) || !stable)
                $display("FAIL random din=%0d: lat %0d bcd %h stable %0d want lat 8 bcd %h stable 1", v, lat, bcd, stable, bcd_model(v));
            else pass_cnt++;
`ifdef CALC_BCD_SEVEN_SEG_EN
            total_cnt++;
            if (seg !== seg_model(v)) $display("FAIL random_seg din=%0d: got %h want %h", v, seg, seg_model(v));
            else pass_cnt++;
`endif
            cyc();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] e;
        int pulses = 0;
        in_valid = 1;
        for (int j = 0; j < 110; j++) begin
            din = 8'($urandom);
            if (in_ready) q.push_back(din);
            cyc();
            if (done) begin
                pulses++;
                total_cnt++;
                if (q.size() == 0) $display("FAIL b2b_spurious_done: got done with nothing accepted");
                else begin
                    e = q.pop_front();
                    if (bcd !== bcd_model(e)) $display("FAIL b2b_bcd din=%0d: got %h want %h", e, bcd, bcd_model(e));
                    else pass_cnt++;
                end
            end
        end
        in_valid = 0;
        for (int j = 0; j < 20; j++) begin
            cyc();
            if (done) begin
                pulses++;
                total_cnt++;
                if (q.size() == 0) $display("FAIL b2b_spurious_done: got done with nothing accepted");
                else begin
                    e = q.pop_front();
                    if (bcd !== bcd_model(e)) $display("FAIL b2b_bcd din=%0d: got %h want %h", e, bcd, bcd_model(e));
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (q.size() != 0 || pulses != 11) $display("FAIL b2b_count: pending %0d pulses %0d want 0 and 11", q.size(), pulses);
        else pass_cnt++;
    endtask

    task automatic test_enable();
        int lat = -1;
        bit frozen_ok = 1;
        logic [11:0] held;
        enb = 0;
        in_valid = 1;
        din = 8'd77;
        cyc();
        cyc();
        in_valid = 0;
        total_cnt++;
        if ({in_ready, busy} !== 2'b10) $display("FAIL enb_low_no_accept: rdy/busy got %b%b want 10", in_ready, busy);
        else pass_cnt++;
        enb = 1;
        din = 8'd99;
        in_valid = 1;
        cyc();
        in_valid = 0;
        for (int n = 1; n <= 40; n++) begin
            enb = (n >= 4 && n <= 6) ? 0 : 1;
            din = 8'($urandom);
            cyc();
            if (n >= 4 && n <= 6 && busy !== 1'b1) frozen_ok = 0;
            if (done) begin
                lat = n;
                break;
            end
        end
        total_cnt++;
        if (lat !== 11 || !frozen_ok) $display("FAIL enb_latency: got %0d (frozen_ok %0d) want 11", lat, frozen_ok);
        else pass_cnt++;
        total_cnt++;
        if (bcd !== 12'h099) $display("FAIL enb_bcd: got %h want 099", bcd);
        else pass_cnt++;
        held = bcd;
        enb = 0;
        for (int n = 0; n < 4; n++) begin
            cyc();
            total_cnt++;
            if ({done, in_ready, bcd} !== {1'b1, 1'b0, held}) $display("FAIL enb_done_hold: done/rdy/bcd got %b%b %h want 10 %h", done, in_ready, bcd, held);
            else pass_cnt++;
        end
        enb = 1;
        cyc();
        total_cnt++;
        if ({done, in_ready} !== 2'b01) $display("FAIL enb_done_release: done/rdy got %b%b want 01", done, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit stable;
        bit seen = 0;
        din = 8'd200;
        in_valid = 1;
        cyc();
        in_valid = 0;
        cyc();
        cyc();
        cyc();
        rst = 1;
        enb = 0;
        cyc();
        rst = 0;
        total_cnt++;
        if ({busy, done, bcd, in_ready} !== {1'b0, 1'b0, 12'h000, 1'b1})
            $display("FAIL reset_mid: busy/done/bcd/rdy got %b%b %h %b want 00 000 1", busy, done, bcd, in_ready);
        else pass_cnt++;
        enb = 1;
        for (int n = 0; n < 12; n++) begin
            cyc();
            if (done || busy) seen = 1;
        end
        total_cnt++;
        if (seen) $display("FAIL reset_mid_no_done: got activity after reset want none");
        else pass_cnt++;
        do_conv(8'd16, lat, stable);
        total_cnt++;
        if (lat !== 8 || bcd !== 12'h016) $display("FAIL reset_mid_next: lat %0d bcd %h want 8 016", lat, bcd);
        else pass_cnt++;
        cyc();
    endtask

    task automatic test_hold();
        int lat;
        bit stable;
        do_conv(8'd128, lat, stable);
        total_cnt++;
        if (bcd !== 12'h128) $display("FAIL hold_setup: got %h want 128", bcd);
        else pass_cnt++;
        cyc();
        for (int n = 0; n < 20; n++) begin
            din = ~din;
            cyc();
            total_cnt++;
            if ({bcd, done} !== {12'h128, 1'b0}) $display("FAIL hold: bcd/done got %h %b want 128 0", bcd, done);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/calc_bcd_display.md
Name: calc_bcd_display

Overview:
- Downstream stage of the 8-bit calculator. Consumes the calculator result bus `c` and converts it to packed BCD for the board display.
- Conversion is iterative (shift-and-add-3, "double dabble"): one bit per clock under `enb`.
- Valid/ready handshake in; one-cycle `done` pulse out. The result is held in a register until the next conversion completes.

Parameters:
- WIDTH, 8: binary input width.
- DIGITS, 3: BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH − 1; compile-time error otherwise.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- enb  input  1  clock enable; low freezes all internal state
- in_valid  input  1  din is valid this cycle
- in_ready  output  1  block can accept a new value
- din  input  WIDTH  binary value, unsigned (calculator `c`)
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse; bcd freshly updated
- bcd  output  4*DIGITS  packed BCD, most significant digit at MSBs

Behaviour:
- Reset (rst high at a rising edge, overrides everything, including enb=0):
  - state=IDLE, bcd=0, done=0, busy=0, in_ready=1.
  - Scratch and counter cleared.
  - An in-flight conversion is discarded; no done pulse is produced for it.
- States: IDLE, SHIFT, DONE.
- Outputs decoded from state:
  - in_ready = (state==IDLE)
  - busy = (state==SHIFT)
  - done = (state==DONE)
- IDLE:
  - On an edge with enb=1, in_valid=1: latch din into the shift register, clear the BCD scratch, set count=0, go to SHIFT.
  - in_valid with enb=0 is not accepted.
- SHIFT, each edge with enb=1:
  - Every scratch digit >= 5 gets +3 (all digits evaluated in parallel on pre-shift values).
  - Then {scratch, shreg} shifts left by 1; count increments.
  - On the edge performing shift number WIDTH: load bcd from the post-shift scratch and go to DONE.
- DONE: next edge with enb=1 goes to IDLE.
- Latency: if the accepting edge is E0, shifts occur at E1..EWIDTH and done is high in the cycle after EWIDTH.
  - Default: done high 8 cycles after acceptance; in_ready returns 1 after E(WIDTH+1).
- enb=0 in any state: state, count, scratch and bcd hold.
  - If frozen in DONE, done stays high until enb returns and the DONE→IDLE edge occurs.
- in_valid while not IDLE: ignored, no queuing. din changes during SHIFT have no effect (latched copy used).
- Boundary values:
  - din=0 gives bcd=0 with full latency (no early exit).
  - din=2^WIDTH−1 gives the exact decimal value.
- bcd is updated only on the final shift edge; it never shows partial results.
- Internal widths:
  - count is $clog2(WIDTH+1) bits.
  - Scratch is 4*DIGITS bits; the add-3 is applied per 4-bit digit with no carry between digits.

Optional Feature:
- Macro: CALC_BCD_SEVEN_SEG_EN
- With the macro defined, the block adds output seg [7*DIGITS-1:0]:
  - 7 active-high segments per digit, order gfedcba, most significant digit at MSBs.
  - Registered; loaded on the same edge as bcd.
  - Leading-zero blanking: leading zero digits output 7'b0000000; the least significant digit always displays, so 0 shows as a single "0" (7'b0111111).
  - Reset value is all zeros (blank).
- Without the macro, the seg port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then din=8'd2 (1+1), in_valid for one cycle, enb=1 → done exactly 8 cycles after the accept edge, bcd=12'h002, in_ready back after 9 edges.
- din=8'd153 (9*17) → bcd=12'h153. Then din=8'd255 → 12'h255. Then din=0 → 12'h000, full 8-cycle latency. Optional: seg shows "153", "255", blank-blank-"0".
- Back-to-back: in_valid held high continuously with changing din → only values present in IDLE cycles are accepted. Each result is correct; din changes mid-SHIFT do not corrupt the result.
- enb toggled low for 3 cycles mid-SHIFT with din=8'd99 → latency extended by exactly 3 cycles, bcd=12'h099. enb low while in DONE → done stays high until enb=1.
- rst asserted during SHIFT (din=8'd200) → next edge: busy=0, done=0, bcd=0, in_ready=1, and no done pulse follows. A new din=8'd16 then converts to 12'h016.
- Hold: after bcd=12'h128, 20 idle cycles with in_valid=0 and din toggling → bcd stays 12'h128 and done stays 0.
